// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the single-cycle RV32I datapath: owns the PC, fetches over req/ack, strobes exec_en.
// Optional retired-instruction counter enabled by defining ARISCO_RETIRE_COUNT_EN.
module instr_sequencer #(
  parameter int unsigned           PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                step,
  input  logic                clear,
  output logic                fetch_req,
  output logic [PC_WIDTH-1:0] fetch_addr,
  input  logic                fetch_ack,
  input  logic [31:0]         fetch_data,
  output logic [31:0]         instruction,
  output logic                exec_en,
  output logic                halted,
  output logic                illegal,
  output logic [PC_WIDTH-1:0] pc
`ifdef ARISCO_RETIRE_COUNT_EN
  ,output logic [31:0]        retired
`endif
);

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic                  halted_q, halted_d;
  logic                  illegal_q, illegal_d;
  logic                  oneshot_q, oneshot_d;
  logic                  legal;

  always_comb begin
    unique case (instr_q[6:0])
      7'b0110011, 7'b0010011, 7'b0110111: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  // Outputs decoded from state only, so no input reaches them combinationally.
  assign fetch_req   = (state_q == S_FETCH);
  assign fetch_addr  = pc_q;
  assign exec_en     = (state_q == S_EXEC) && legal;
  assign instruction = instr_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign pc          = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    oneshot_d = oneshot_q;
    if (clear) begin
      state_d   = S_IDLE;
      pc_d      = RESET_PC;
      instr_d   = NOP;
      halted_d  = 1'b0;
      illegal_d = 1'b0;
      oneshot_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run || step) state_d = S_FETCH;
          if (step)        oneshot_d = 1'b1;
        end
        S_FETCH: begin
          if (fetch_ack) begin
            instr_d = fetch_data;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          oneshot_d = 1'b0;
          if (legal) begin
            pc_d    = pc_q + PC_WIDTH'(4);
            state_d = (run && !oneshot_q) ? S_FETCH : S_IDLE;
          end else begin
            halted_d  = 1'b1;
            illegal_d = (instr_q != EBREAK);
            state_d   = S_HALT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      oneshot_q <= oneshot_d;
    end
  end

`ifdef ARISCO_RETIRE_COUNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (clear)        retired_d = '0;
    else if (exec_en) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule
